// File: rtl/depp_regbank_pkg.sv
// depp_regbank_pkg
// Shared definitions for the DEPP register bank: FSM state encoding and the
// bit positions inside the control and status registers.
// No ports.

package depp_regbank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OVR  = 2;

endpackage

// File: rtl/depp_regbank_we_sync.sv
// depp_we_sync
// Brings the slow-domain host write strobe into clkFast and turns each
// host write (a level held for at least one slow cycle) into a single
// one-cycle write event.
// Ports:
//   clkFast  in   core clock
//   rst      in   asynchronous reset, active-low
//   mem_we   in   host write strobe (slow domain, level)
//   wr_ev    out  one-cycle pulse, high in the 3rd cycle after mem_we rises

module depp_we_sync (
    input  logic clkFast,
    input  logic rst,
    input  logic mem_we,
    output logic wr_ev
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clkFast or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= mem_we;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // s1/s2 form the synchroniser; s3 only serves edge detection.
    assign wr_ev = s2 & ~s3;

endmodule

// File: rtl/depp_regbank.sv
// depp_regbank
// Parametrised register bank between the DEPP memory port and a user
// compute core. Input registers feed the core, output registers capture the
// core results on completion, and a control/status pair drives a
// start/done handshake.
// Optional feature: define DEPP_REGBANK_AUTOSTART_EN so that a committed
// write to the last input register (IN_DEPTH-1) also starts the core.
// Ports:
//   clkFast    in   core clock
//   rst        in   asynchronous reset, active-low
//   mem_we     in   host write strobe (slow domain, level)
//   mem_adr    in   host address
//   mem_idata  in   host write data
//   mem_odata  out  host read data (combinational from mem_adr)
//   core_in    out  flattened input registers, reg i at [i*DATA_W +: DATA_W]
//   core_start out  one-cycle start pulse
//   core_out   in   flattened core results
//   core_done  in   one-cycle completion pulse

module depp_regbank
    import depp_regbank_pkg::*;
#(
    parameter  int ADDR_W    = 8,
    parameter  int DATA_W    = 8,
    parameter  int IN_DEPTH  = 128,
    localparam int OUT_DEPTH = (1 << ADDR_W) - IN_DEPTH - 2
) (
    input  logic                          clkFast,
    input  logic                          rst,
    input  logic                          mem_we,
    input  logic [ADDR_W-1:0]             mem_adr,
    input  logic [DATA_W-1:0]             mem_idata,
    output logic [DATA_W-1:0]             mem_odata,
    output logic [IN_DEPTH*DATA_W-1:0]    core_in,
    output logic                          core_start,
    input  logic [OUT_DEPTH*DATA_W-1:0]   core_out,
    input  logic                          core_done
);

    localparam logic [ADDR_W-1:0] LAST_IN_A = ADDR_W'(IN_DEPTH - 1);
    localparam logic [ADDR_W-1:0] CTRL_A    = ADDR_W'((1 << ADDR_W) - 2);
    localparam logic [ADDR_W-1:0] STAT_A    = ADDR_W'((1 << ADDR_W) - 1);

`ifdef DEPP_REGBANK_AUTOSTART_EN
    localparam bit AUTOSTART = 1'b1;
`else
    localparam bit AUTOSTART = 1'b0;
`endif

    state_t                         state;
    logic                           busy;
    logic                           done;
    logic                           overrun;
    logic [IN_DEPTH*DATA_W-1:0]     in_flat;
    logic [OUT_DEPTH*DATA_W-1:0]    out_flat;
    logic [DATA_W-1:0]              rdata;

    logic wr_ev;
    logic wr_in;
    logic wr_ctrl;
    logic clr;
    logic start;

    depp_we_sync u_we_sync (
        .clkFast (clkFast),
        .rst     (rst),
        .mem_we  (mem_we),
        .wr_ev   (wr_ev)
    );

    // mem_adr/mem_idata are held stable by the host while mem_we is high,
    // so sampling them directly on the wr_ev cycle is safe.
    assign wr_in   = wr_ev && (mem_adr <= LAST_IN_A);
    assign wr_ctrl = wr_ev && (mem_adr == CTRL_A);
    assign clr     = wr_ctrl && mem_idata[CTRL_CLEAR];
    assign start   = (wr_ctrl && mem_idata[CTRL_START] && !mem_idata[CTRL_CLEAR])
                   || (AUTOSTART && wr_in && (mem_adr == LAST_IN_A));

    always_ff @(posedge clkFast or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
            core_start <= 1'b0;
            in_flat    <= '0;
            out_flat   <= '0;
        end else begin
            core_start <= 1'b0;
            if (clr) begin
                // CLEAR wins over everything, including a same-cycle core_done.
                state    <= ST_IDLE;
                busy     <= 1'b0;
                done     <= 1'b0;
                overrun  <= 1'b0;
                in_flat  <= '0;
                out_flat <= '0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (wr_in) begin
                            for (int i = 0; i < IN_DEPTH; i++) begin
                                if (mem_adr == ADDR_W'(i)) begin
                                    in_flat[i*DATA_W +: DATA_W] <= mem_idata;
                                end
                            end
                        end
                        if (start) begin
                            state      <= ST_RUN;
                            core_start <= 1'b1;
                            busy       <= 1'b1;
                            done       <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        // Inputs are frozen while the core works on them.
                        if (wr_in || start) begin
                            overrun <= 1'b1;
                        end
                        if (core_done) begin
                            out_flat <= core_out;
                            state    <= ST_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < IN_DEPTH; i++) begin
            if (mem_adr == ADDR_W'(i)) begin
                rdata = in_flat[i*DATA_W +: DATA_W];
            end
        end
        for (int j = 0; j < OUT_DEPTH; j++) begin
            if (mem_adr == ADDR_W'(IN_DEPTH + j)) begin
                rdata = out_flat[j*DATA_W +: DATA_W];
            end
        end
        if (mem_adr == STAT_A) begin
            rdata[STAT_BUSY] = busy;
            rdata[STAT_DONE] = done;
            rdata[STAT_OVR]  = overrun;
        end
    end

    assign mem_odata = rdata;
    assign core_in   = in_flat;

endmodule

// File: tb/tb_depp_regbank.sv
// tb_depp_regbank
// Directed sequence with randomised data for the DEPP register bank, checked
// against a flag/array model of the register bank's documented behaviour.

module tb_depp_regbank;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int IN_DEPTH  = 128;
    localparam int OUT_DEPTH = (1 << ADDR_W) - IN_DEPTH - 2;
    localparam int IN_W      = IN_DEPTH * DATA_W;
    localparam int OUT_W     = OUT_DEPTH * DATA_W;
    localparam int CTRL      = (1 << ADDR_W) - 2;
    localparam int STAT      = (1 << ADDR_W) - 1;

`ifdef DEPP_REGBANK_AUTOSTART_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic                clkFast = 1'b0;
    logic                rst;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_adr;
    logic [DATA_W-1:0]   mem_idata;
    logic [DATA_W-1:0]   mem_odata;
    logic [IN_W-1:0]     core_in;
    logic                core_start;
    logic [OUT_W-1:0]    core_out;
    logic                core_done;

    depp_regbank #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .IN_DEPTH (IN_DEPTH)
    ) dut (
        .clkFast    (clkFast),
        .rst        (rst),
        .mem_we     (mem_we),
        .mem_adr    (mem_adr),
        .mem_idata  (mem_idata),
        .mem_odata  (mem_odata),
        .core_in    (core_in),
        .core_start (core_start),
        .core_out   (core_out),
        .core_done  (core_done)
    );

    always #5 clkFast = ~clkFast;

    int vectors     = 0;
    int miscompares = 0;
    int starts_seen = 0;

    always @(posedge clkFast) begin
        if (core_start === 1'b1) starts_seen++;
    end

    // Reference model
    logic [7:0] m_in  [IN_DEPTH];
    logic [7:0] m_out [OUT_DEPTH];
    bit         m_busy;
    bit         m_done;
    bit         m_ovr;
    int         m_starts = 0;

    function automatic void model_reset();
        foreach (m_in[i])  m_in[i]  = 8'h00;
        foreach (m_out[j]) m_out[j] = 8'h00;
        m_busy = 0;
        m_done = 0;
        m_ovr  = 0;
    endfunction

    // One clkFast edge of host-visible behaviour: optional committed write,
    // optional core_done.
    function automatic void model_event(input int adr, input logic [7:0] data,
                                        input bit wr, input bit dn,
                                        input logic [OUT_W-1:0] cout);
        bit is_in  = wr && (adr < IN_DEPTH);
        bit clear  = wr && (adr == CTRL) && data[1];
        bit strt   = (wr && (adr == CTRL) && data[0] && !data[1])
                   || (AUTO && is_in && (adr == IN_DEPTH - 1));
        if (clear) begin
            model_reset();
            return;
        end
        if (m_busy) begin
            if (is_in || strt) m_ovr = 1;
            if (dn) begin
                for (int j = 0; j < OUT_DEPTH; j++) m_out[j] = cout[j*8 +: 8];
                m_busy = 0;
                m_done = 1;
            end
        end else begin
            if (is_in) m_in[adr] = data;
            if (strt) begin
                m_busy = 1;
                m_done = 0;
                m_starts++;
            end
        end
    endfunction

    function automatic logic [7:0] exp_stat();
        return {5'b0, m_ovr, m_done, m_busy};
    endfunction

    function automatic logic [IN_W-1:0] exp_core_in();
        logic [IN_W-1:0] v;
        for (int i = 0; i < IN_DEPTH; i++) v[i*8 +: 8] = m_in[i];
        return v;
    endfunction

    function automatic logic [OUT_W-1:0] rand_cout();
        logic [OUT_W-1:0] v;
        for (int j = 0; j < OUT_DEPTH; j++) v[j*8 +: 8] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_core_in(input string tag);
        logic [IN_W-1:0] e;
        int bad;
        e = exp_core_in();
        vectors++;
        assert (core_in === e) else begin
            miscompares++;
            bad = 0;
            for (int i = IN_DEPTH - 1; i >= 0; i--)
                if (core_in[i*8 +: 8] !== e[i*8 +: 8]) bad = i;
            $error("FAIL %s core_in byte %0d observed=0x%0h expected=0x%0h",
                   tag, bad, core_in[bad*8 +: 8], e[bad*8 +: 8]);
        end
    endtask

    task automatic read_chk(input int adr, input logic [7:0] exp, input string tag);
        @(negedge clkFast);
        mem_adr = ADDR_W'(adr);
        #1;
        check(tag, {24'b0, mem_odata}, {24'b0, exp});
    endtask

    task automatic check_state(input string tag);
        read_chk(STAT, exp_stat(), {tag, "_stat"});
        check_core_in({tag, "_core_in"});
        check({tag, "_starts"}, 32'(starts_seen), 32'(m_starts));
    endtask

    task automatic check_out_all(input string tag);
        for (int j = 0; j < OUT_DEPTH; j++) read_chk(IN_DEPTH + j, m_out[j], tag);
    endtask

    task automatic host_write(input int adr, input logic [7:0] data, input int nslow);
        @(negedge clkFast);
        mem_adr   = ADDR_W'(adr);
        mem_idata = data;
        mem_we    = 1'b1;
        repeat (nslow * 4) @(posedge clkFast);
        @(negedge clkFast);
        mem_we = 1'b0;
        repeat (4) @(posedge clkFast);
        model_event(adr, data, 1, 0, '0);
    endtask

    // Host write whose commit edge coincides with a core_done pulse.
    task automatic host_write_done(input int adr, input logic [7:0] data,
                                   input logic [OUT_W-1:0] cout);
        @(negedge clkFast);
        mem_adr   = ADDR_W'(adr);
        mem_idata = data;
        mem_we    = 1'b1;
        @(posedge clkFast);
        @(posedge clkFast);
        @(negedge clkFast);
        core_done = 1'b1;
        core_out  = cout;
        @(posedge clkFast);
        @(negedge clkFast);
        core_done = 1'b0;
        repeat (4) @(posedge clkFast);
        @(negedge clkFast);
        mem_we = 1'b0;
        repeat (4) @(posedge clkFast);
        model_event(adr, data, 1, 1, cout);
    endtask

    task automatic pulse_done(input logic [OUT_W-1:0] cout);
        @(negedge clkFast);
        core_done = 1'b1;
        core_out  = cout;
        @(negedge clkFast);
        core_done = 1'b0;
        model_event(0, 8'h00, 0, 1, cout);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OUT_W-1:0] cout;
        int               a;
        logic [7:0]       d;

        rst       = 1'b0;
        mem_we    = 1'b0;
        mem_adr   = '0;
        mem_idata = '0;
        core_out  = '0;
        core_done = 1'b0;
        model_reset();
        repeat (3) @(posedge clkFast);
        #2;
        check("reset_core_start", {31'b0, core_start}, 32'd0);
        @(negedge clkFast);
        rst = 1'b1;

        check_state("reset");
        read_chk(3, 8'h00, "reset_adr3");
        read_chk(IN_DEPTH, 8'h00, "reset_adr_out0");
        read_chk(CTRL, 8'h00, "reset_ctrl");

        // Commit latency: the register changes on the 3rd edge after mem_we rises.
        @(negedge clkFast);
        mem_adr   = 8'd3;
        mem_idata = 8'h5A;
        mem_we    = 1'b1;
        @(posedge clkFast); #1;
        check("lat_edge1", {24'b0, core_in[3*8 +: 8]}, 32'h00);
        @(posedge clkFast); #1;
        check("lat_edge2", {24'b0, core_in[3*8 +: 8]}, 32'h00);
        @(posedge clkFast); #1;
        check("lat_edge3", {24'b0, core_in[3*8 +: 8]}, 32'h5A);
        repeat (13) @(posedge clkFast);
        @(negedge clkFast);
        mem_we = 1'b0;
        repeat (4) @(posedge clkFast);
        model_event(3, 8'h5A, 1, 0, '0);
        read_chk(3, 8'h5A, "lat_read_adr3");
        check_state("lat");

        // Random input writes with readback.
        for (int k = 0; k < 6; k++) begin
            a = $urandom_range(0, IN_DEPTH - 2);
            d = 8'($urandom_range(0, 255));
            host_write(a, d, 1 + (k % 2));
            read_chk(a, m_in[a], "rand_in_read");
        end
        check_state("rand_in");

        // Writes to the output region and to STAT are ignored.
        a = IN_DEPTH + $urandom_range(0, OUT_DEPTH - 1);
        host_write(a, 8'h77, 1);
        read_chk(a, 8'h00, "out_region_write_ignored");
        host_write(STAT, 8'h07, 1);
        check_state("stat_write_ignored");

        // Start held 4 slow cycles: one commit, so no overrun.
        host_write(CTRL, 8'h01, 4);
        check_state("start1");

        cout = rand_cout();
        cout[7:0] = 8'hC3;
        pulse_done(cout);
        read_chk(IN_DEPTH, 8'hC3, "done1_adr128");
        check_out_all("done1_out");
        check_state("done1");

        // Restart from DONE, then disturb RUN.
        host_write(CTRL, 8'h01, 1);
        check_state("start2");
        d = m_in[5];
        host_write(5, 8'hFF, 1);
        read_chk(5, d, "run_write_dropped");
        host_write(CTRL, 8'h01, 1);
        check_state("run_start_dropped");
        pulse_done(rand_cout());
        check_out_all("done2_out");
        check_state("done2");

        // core_done outside RUN is ignored.
        pulse_done({OUT_DEPTH{8'hAA}});
        check_out_all("done_in_done_ignored");

        // START and core_done on the same edge in RUN.
        host_write(CTRL, 8'h01, 1);
        host_write_done(CTRL, 8'h01, rand_cout());
        check_out_all("done_with_start_out");
        check_state("done_with_start");

        // CLEAR|START from DONE.
        host_write(CTRL, 8'h03, 1);
        check_state("clear_in_done");
        check_out_all("clear_in_done_out");

        pulse_done({OUT_DEPTH{8'hAA}});
        read_chk(IN_DEPTH, 8'h00, "done_in_idle_adr128");
        read_chk(IN_DEPTH + OUT_DEPTH - 1, 8'h00, "done_in_idle_last");
        check_state("done_in_idle");

        // CLEAR on the same edge as core_done in RUN discards the results.
        host_write(9, 8'h3C, 1);
        host_write(CTRL, 8'h01, 1);
        host_write_done(CTRL, 8'h02, rand_cout());
        check_out_all("clear_vs_done_out");
        check_state("clear_vs_done");

        // Async reset mid-RUN.
        host_write(12, 8'($urandom_range(1, 255)), 1);
        host_write(CTRL, 8'h01, 1);
        check_state("pre_reset_run");
        @(negedge clkFast);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("async_core_start", {31'b0, core_start}, 32'd0);
        read_chk(STAT, 8'h00, "async_stat");
        check_core_in("async_core_in");
        #3 rst = 1'b1;
        pulse_done({OUT_DEPTH{8'hAA}});
        read_chk(IN_DEPTH, 8'h00, "post_reset_done_ignored");
        check_state("post_reset");

        // Last input register: starts the core only with the autostart build.
        host_write(IN_DEPTH - 1, 8'h11, 1);
        read_chk(IN_DEPTH - 1, 8'h11, "last_in_read");
        check_state("last_in_write");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
